// File: rtl/branch_target_buffer_pkg.sv
// Shared types and constants for the branch target buffer.
// Pure definitions; no latency, no flow control.
package bpb_pkg;

  typedef logic [1:0] bpb_cnt_t;

  localparam bpb_cnt_t CNT_INIT = 2'b01;
  localparam bpb_cnt_t CNT_MAX  = 2'b11;
  localparam bpb_cnt_t CNT_MIN  = 2'b00;

endpackage

// File: rtl/branch_target_buffer_if.sv
// Lookup, allocation and resolution bundle between fetch/execute/controller and the BTB.
// Master drives requests; slave (the table) answers combinationally, no backpressure.
interface branch_target_buffer_if #(
  parameter int TAG_WIDTH = 30
);
  logic [TAG_WIDTH-1:0] lk_addr;
  logic                 hit;
  logic                 pred_taken;
  logic [TAG_WIDTH-1:0] pred_target;

  logic                 w_en;
  logic                 set_valid;
  logic [TAG_WIDTH-1:0] set_tag;

  logic                 rs_valid;
  logic [TAG_WIDTH-1:0] rs_addr;
  logic                 rs_taken;
  logic [TAG_WIDTH-1:0] rs_target;
  logic                 conflict;

  modport master (
    output lk_addr, w_en, set_valid, set_tag, rs_valid, rs_addr, rs_taken, rs_target,
    input  hit, pred_taken, pred_target, conflict
  );

  modport slave (
    input  lk_addr, w_en, set_valid, set_tag, rs_valid, rs_addr, rs_taken, rs_target,
    output hit, pred_taken, pred_target, conflict
  );
endinterface

// File: rtl/bpb_sat_counter.sv
// Next-state of a 2-bit saturating direction counter; combinational, 0 cycles.
// Holds its value when en is low; no flow control.
module bpb_sat_counter
  import bpb_pkg::*;
(
  input  bpb_cnt_t cnt,
  input  logic     taken,
  input  logic     en,
  output bpb_cnt_t cnt_nxt
);

  always_comb begin
    cnt_nxt = cnt;
    if (en) begin
      if (taken) begin
        if (cnt != CNT_MAX) cnt_nxt = cnt + 2'd1;
      end else if (cnt != CNT_MIN) begin
        cnt_nxt = cnt - 2'd1;
      end
    end
  end

endmodule

// File: rtl/branch_target_buffer.sv
// Fully-associative BTB: 0-cycle lookup/conflict, writes visible next cycle; stall freezes all state.
// Optional statistics counters are built only when BPB_STATS_EN is defined.
module branch_target_buffer
  import bpb_pkg::*;
#(
  parameter int ENTRIES   = 8,
  parameter int TAG_WIDTH = 30
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   flush,
  branch_target_buffer_if.slave  bus,
  output logic [31:0]            st_lookups,
  output logic [31:0]            st_hits,
  output logic [31:0]            st_conflicts
);

  localparam int IW = $clog2(ENTRIES);
  typedef logic [IW-1:0] idx_t;

  typedef struct packed {
    logic                 valid;
    logic [TAG_WIDTH-1:0] tag;
    bpb_cnt_t             cnt;
    logic [TAG_WIDTH-1:0] target;
  } bpb_entry_t;

  bpb_entry_t         tbl [ENTRIES];
  idx_t               rr;
  logic [ENTRIES-1:0] lk_match, al_match, rs_match, cnt_en;
  idx_t               lk_idx, al_idx, rs_idx, wr_idx;
  logic               al_do, al_hit, rs_hit, rs_do;
  bpb_cnt_t           cnt_nxt [ENTRIES];

  // Tags are unique among valid entries, so OR-ing matching indices yields the single hit.
  always_comb begin
    lk_match = '0;
    al_match = '0;
    rs_match = '0;
    lk_idx   = '0;
    al_idx   = '0;
    rs_idx   = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      lk_match[i] = tbl[i].valid && (tbl[i].tag == bus.lk_addr);
      al_match[i] = tbl[i].valid && (tbl[i].tag == bus.set_tag);
      rs_match[i] = tbl[i].valid && (tbl[i].tag == bus.rs_addr);
      if (lk_match[i]) lk_idx |= idx_t'(i);
      if (al_match[i]) al_idx |= idx_t'(i);
      if (rs_match[i]) rs_idx |= idx_t'(i);
    end
  end

  assign bus.hit         = |lk_match;
  assign bus.pred_taken  = bus.hit & tbl[lk_idx].cnt[1];
  assign bus.pred_target = bus.pred_taken ? tbl[lk_idx].target
                                          : bus.lk_addr + TAG_WIDTH'(1);

  assign rs_hit       = |rs_match;
  assign bus.conflict = bus.rs_valid & rs_hit &
                        ((tbl[rs_idx].cnt[1] != bus.rs_taken) |
                         (bus.rs_taken & (tbl[rs_idx].target != bus.rs_target)));

  assign al_do  = bus.w_en & ~flush & ~stall;
  assign al_hit = |al_match;
  assign wr_idx = al_hit ? al_idx : rr;
  assign rs_do  = bus.rs_valid & ~stall & rs_hit;

  // An allocation landing on the resolved entry supersedes the resolution.
  for (genvar g = 0; g < ENTRIES; g++) begin : g_cnt
    assign cnt_en[g] = rs_do & rs_match[g] & ~(al_do & (wr_idx == idx_t'(g)));
    bpb_sat_counter u_cnt (
      .cnt     (tbl[g].cnt),
      .taken   (bus.rs_taken),
      .en      (cnt_en[g]),
      .cnt_nxt (cnt_nxt[g])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tbl[i] <= '{valid: 1'b0, tag: '0, cnt: CNT_INIT, target: '0};
      end
    end else begin
      if (al_do && !al_hit) rr <= rr + idx_t'(1);
      for (int i = 0; i < ENTRIES; i++) begin
        if (al_do && (wr_idx == idx_t'(i))) begin
          tbl[i] <= '{valid: bus.set_valid, tag: bus.set_tag, cnt: CNT_INIT, target: '0};
        end else if (cnt_en[i]) begin
          tbl[i].cnt <= cnt_nxt[i];
          if (bus.rs_taken) tbl[i].target <= bus.rs_target;
        end
      end
    end
  end

`ifdef BPB_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_lookups   <= '0;
      st_hits      <= '0;
      st_conflicts <= '0;
    end else if (!stall) begin
      st_lookups <= st_lookups + 32'd1;
      if (bus.hit)      st_hits      <= st_hits + 32'd1;
      if (bus.conflict) st_conflicts <= st_conflicts + 32'd1;
    end
  end
`else
  assign st_lookups   = '0;
  assign st_hits      = '0;
  assign st_conflicts = '0;
`endif

endmodule

// File: tb/tb_branch_target_buffer.sv
// Random plus directed bench for branch_target_buffer against a table-level reference model.
module tb_branch_target_buffer;

  localparam int N  = 8;
  localparam int TW = 30;

  logic        clk = 1'b0;
  logic        reset, stall, flush;
  logic [31:0] st_l, st_h, st_c;

  branch_target_buffer_if #(.TAG_WIDTH(TW)) bus ();

  branch_target_buffer #(.ENTRIES(N), .TAG_WIDTH(TW)) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .flush        (flush),
    .bus          (bus),
    .st_lookups   (st_l),
    .st_hits      (st_h),
    .st_conflicts (st_c)
  );

  always #5 clk = ~clk;

  // Reference model: plain arrays describing the table contents
  bit              m_valid [N];
  logic [TW-1:0]   m_tag   [N];
  logic [TW-1:0]   m_tgt   [N];
  int              m_cnt   [N];
  int              m_rr;
  int unsigned     m_lk, m_hi, m_cf;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int find(input logic [TW-1:0] a);
    for (int i = 0; i < N; i++)
      if (m_valid[i] && m_tag[i] == a) return i;
    return -1;
  endfunction

  function automatic bit exp_conflict();
    int ri;
    ri = find(bus.rs_addr);
    if (!bus.rs_valid || ri < 0) return 1'b0;
    return ((m_cnt[ri] >= 2) != bus.rs_taken) ||
           (bus.rs_taken && m_tgt[ri] != bus.rs_target);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 1'b0; m_tag[i] = '0; m_tgt[i] = '0; m_cnt[i] = 1;
    end
    m_rr = 0; m_lk = 0; m_hi = 0; m_cf = 0;
  endtask

  task automatic compare();
    int li;
    bit e_pt;
    logic [TW-1:0] e_tgt;
    li    = find(bus.lk_addr);
    e_pt  = (li >= 0) && (m_cnt[li] >= 2);
    e_tgt = e_pt ? m_tgt[li] : TW'(bus.lk_addr + 1);
    chk("hit", bus.hit, li >= 0);
    chk("pred_taken", bus.pred_taken, e_pt);
    chk("pred_target", bus.pred_target, e_tgt);
    chk("conflict", bus.conflict, exp_conflict());
`ifdef BPB_STATS_EN
    chk("st_lookups", st_l, m_lk);
    chk("st_hits", st_h, m_hi);
    chk("st_conflicts", st_c, m_cf);
`else
    chk("st_lookups", st_l, 0);
    chk("st_hits", st_h, 0);
    chk("st_conflicts", st_c, 0);
`endif
  endtask

  task automatic model_update();
    int ai, ri;
    if (stall) return;
    m_lk++;
    if (find(bus.lk_addr) >= 0) m_hi++;
    if (exp_conflict()) m_cf++;
    ai = -1;
    if (bus.w_en && !flush) begin
      ai = find(bus.set_tag);
      if (ai < 0) begin
        ai   = m_rr;
        m_rr = (m_rr + 1) % N;
      end
    end
    ri = find(bus.rs_addr);
    if (bus.rs_valid && ri >= 0 && ri != ai) begin
      if (bus.rs_taken) begin
        if (m_cnt[ri] < 3) m_cnt[ri]++;
        m_tgt[ri] = bus.rs_target;
      end else if (m_cnt[ri] > 0) begin
        m_cnt[ri]--;
      end
    end
    if (ai >= 0) begin
      m_valid[ai] = bus.set_valid; m_tag[ai] = bus.set_tag;
      m_cnt[ai] = 1; m_tgt[ai] = '0;
    end
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic cyc();
    #1;
    compare();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    stall = 0; flush = 0;
    bus.w_en = 0; bus.set_valid = 0; bus.set_tag = '0;
    bus.rs_valid = 0; bus.rs_addr = '0; bus.rs_taken = 0; bus.rs_target = '0;
  endtask

  // Asserted between edges so any pending write in the current cycle is lost.
  task automatic do_reset();
    #2 reset = 1;
    model_reset();
    #1;
    chk("rst_hit", bus.hit, 0);
    chk("rst_conflict", bus.conflict, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 0;
    idle();
  endtask

  task automatic alloc(input logic [TW-1:0] t);
    idle(); bus.w_en = 1; bus.set_valid = 1; bus.set_tag = t;
    cyc(); idle();
  endtask

  task automatic resolve(input logic [TW-1:0] a, input bit tk, input logic [TW-1:0] tg);
    idle(); bus.rs_valid = 1; bus.rs_addr = a; bus.rs_taken = tk; bus.rs_target = tg;
    cyc(); idle();
  endtask

  function automatic logic [TW-1:0] rtag();
    return TW'(32'h100 + $urandom_range(0, 11));
  endfunction

  initial begin
    reset = 1; idle(); bus.lk_addr = '0;
    model_reset();
    @(negedge clk); @(negedge clk);
    reset = 0;

    // Empty table lookup
    bus.lk_addr = TW'(32'h100);
    #1;
    chk("empty_hit", bus.hit, 0);
    chk("empty_pt", bus.pred_taken, 0);
    chk("empty_tgt", bus.pred_target, 32'h101);
    cyc();

    // Train taken twice
    alloc(TW'(32'h100));
    resolve(TW'(32'h100), 1, TW'(32'h200));
    resolve(TW'(32'h100), 1, TW'(32'h200));
    bus.lk_addr = TW'(32'h100);
    #1;
    chk("train_hit", bus.hit, 1);
    chk("train_pt", bus.pred_taken, 1);
    chk("train_tgt", bus.pred_target, 32'h200);
    cyc();

    // Target mismatch conflict and retarget
    idle(); bus.rs_valid = 1; bus.rs_addr = TW'(32'h100); bus.rs_taken = 1; bus.rs_target = TW'(32'h300);
    #1;
    chk("tgt_conflict", bus.conflict, 1);
    cyc(); idle();
    #1;
    chk("retarget", bus.pred_target, 32'h300);
    cyc();

    // Not-taken saturation at 00
    alloc(TW'(32'h180));
    bus.rs_valid = 1; bus.rs_addr = TW'(32'h180); bus.rs_taken = 0;
    #1;
    chk("nt_no_conflict", bus.conflict, 0);
    cyc();
    resolve(TW'(32'h180), 0, '0);
    resolve(TW'(32'h180), 0, '0);
    resolve(TW'(32'h180), 1, TW'(32'h40));
    bus.lk_addr = TW'(32'h180);
    #1;
    chk("sat_low_pt", bus.pred_taken, 0);
    cyc();

    // Round-robin eviction
    do_reset();
    for (int i = 0; i <= N; i++) alloc(TW'(32'h400 + i));
    bus.lk_addr = TW'(32'h400);
    #1; chk("evict_first", bus.hit, 0); cyc();
    bus.lk_addr = TW'(32'h401);
    #1; chk("keep_second", bus.hit, 1); cyc();
    alloc(TW'(32'h403));
    alloc(TW'(32'h500));
    bus.lk_addr = TW'(32'h401);
    #1; chk("rr_at_one", bus.hit, 0); cyc();
    bus.lk_addr = TW'(32'h403);
    #1; chk("rehit_kept", bus.hit, 1); cyc();

    // Fall-through address wrap
    bus.lk_addr = '1;
    #1; chk("wrap_tgt", bus.pred_target, 0); cyc();

    // Statistics and stall
    do_reset();
    bus.w_en = 1; bus.set_valid = 1; bus.set_tag = TW'(32'h100); bus.lk_addr = TW'(32'h100);
    cyc(); idle();
    for (int i = 0; i < 9; i++) begin
      bus.lk_addr = (i < 4) ? TW'(32'h100) : TW'(32'h999);
      cyc();
    end
    #1;
`ifdef BPB_STATS_EN
    chk("stat_lookups", st_l, 10);
    chk("stat_hits", st_h, 4);
`endif
    for (int i = 0; i < 2; i++) begin
      stall = 1; bus.w_en = 1; bus.set_valid = 1; bus.set_tag = TW'(32'h777);
      bus.rs_valid = 1; bus.rs_addr = TW'(32'h100); bus.rs_taken = 1; bus.rs_target = TW'(32'h50);
      bus.lk_addr = TW'(32'h100);
      cyc();
    end
    idle();
    #1;
`ifdef BPB_STATS_EN
    chk("stall_lookups", st_l, 10);
    chk("stall_hits", st_h, 4);
`endif
    chk("stall_cnt", bus.pred_taken, 0);
    cyc();
    bus.lk_addr = TW'(32'h777);
    #1; chk("stall_no_alloc", bus.hit, 0); cyc();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        stall         = ($urandom_range(0, 99) < 15);
        flush         = ($urandom_range(0, 99) < 15);
        bus.w_en      = ($urandom_range(0, 99) < 30);
        bus.set_valid = ($urandom_range(0, 99) < 90);
        bus.set_tag   = rtag();
        bus.rs_valid  = ($urandom_range(0, 99) < 50);
        bus.rs_addr   = rtag();
        bus.rs_taken  = $urandom_range(0, 1);
        bus.rs_target = ($urandom_range(0, 1) == 1) ? TW'(32'h200) : TW'($urandom);
        bus.lk_addr   = ($urandom_range(0, 15) == 0) ? '1 : rtag();
        cyc();
      end
    end

    // Reset during an allocation drops the write
    idle();
    bus.w_en = 1; bus.set_valid = 1; bus.set_tag = TW'(32'h900); bus.lk_addr = TW'(32'h900);
    do_reset();
    bus.lk_addr = TW'(32'h900);
    #1; chk("reset_drops_write", bus.hit, 0); cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
